// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the clock digit unit
// Purpose: display mode enum, field port indices, BCD digit type and the
//          converter FSM state enum used by clock_digit_unit.
package display_pkg;

    typedef enum logic [1:0] {
        MODE_HHMMSS = 2'd0,
        MODE_YYMMDD = 2'd1,
        MODE_YYYYMM = 2'd2
    } mode_t;

    localparam int PORT_SEC        = 0;
    localparam int PORT_MIN        = 1;
    localparam int PORT_HOUR       = 2;
    localparam int PORT_DAY        = 3;
    localparam int PORT_MONTH      = 4;
    localparam int PORT_YEAR       = 5;
    localparam int NUM_FIELD_PORTS = 6;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } conv_state_t;

endpackage

// File: rtl/clock_digit_unit_bin2bcd_serial.sv
// rtl/clock_digit_unit_bin2bcd_serial.sv - sequential shift-add-3 binary to BCD converter
// Purpose: one bit per cycle double-dabble conversion.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   start       load value, clear accumulator and counter
//   value       binary input (DATA_W bits)
//   shift_en    perform one correct-and-shift step
//   done        high during the final shift step
//   bcd         BCD accumulator (BCD_DIGITS nibbles, nibble 0 = ones)
module bin2bcd_serial
    import display_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    input  logic                    shift_en,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic [BCD_W-1:0]  w_adj;

    // Nibbles >= 5 get +3 so the following left shift carries into the next digit.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_bin <= value;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (shift_en) begin
            {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + 1'b1;
        end
    end

    assign done = shift_en && (r_cnt == LAST_CNT);
    assign bcd  = r_bcd;

endmodule

// File: rtl/clock_digit_unit.sv
// rtl/clock_digit_unit.sv - latches time/date port writes, converts to BCD, drives six digits
// Purpose: capture Driver port writes, convert dirty fields one at a time
//          through bin2bcd_serial, and drive registered digits for the mode.
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   write_out/out_port/out_data  port write strobe, index and value
//   select_*_button              display mode select levels
//   digit5..digit0               registered BCD digits, digit5 leftmost
//   busy                         converter not idle
module clock_digit_unit
    import display_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_PORTS  = 6,
    parameter int BCD_DIGITS = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              write_out,
    input  logic [3:0]        out_port,
    input  logic [DATA_W-1:0] out_data,
    input  logic              select_hhmmss_button,
    input  logic              select_yymmdd_button,
    input  logic              select_yyyymm_button,
    output logic [3:0]        digit5,
    output logic [3:0]        digit4,
    output logic [3:0]        digit3,
    output logic [3:0]        digit2,
    output logic [3:0]        digit1,
    output logic [3:0]        digit0,
    output logic              busy
);

    localparam int BCD_W  = 4 * BCD_DIGITS;
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0][DATA_W-1:0] r_bin;
    logic [PORT_YEAR-1:0][7:0]        r_bcd2;     // two-digit fields sec..month
    logic [15:0]                      r_year_bcd;
    logic [NUM_PORTS-1:0]             r_dirty;
    logic [PORT_W-1:0]                r_port;
    conv_state_t                      r_state;
    mode_t                            r_mode;
    bcd_digit_t                       r_d5, r_d4, r_d3, r_d2, r_d1, r_d0;

    conv_state_t          w_next;
    logic                 w_start;
    logic                 w_shift_en;
    logic                 w_store;
    logic                 w_done;
    logic [BCD_W-1:0]     w_conv_bcd;
    logic                 w_wr_hit;
    logic [PORT_W-1:0]    w_wr_idx;
    logic                 w_pick_valid;
    logic [PORT_W-1:0]    w_pick_idx;
    logic [NUM_PORTS-1:0] w_set;
    logic [NUM_PORTS-1:0] w_clr;
    logic                 w_unused_bcd;

    assign w_wr_hit = write_out && (out_port < 4'(NUM_PORTS));
    assign w_wr_idx = out_port[PORT_W-1:0];

    // Lowest-index dirty port wins; scan downward so the last hit is the lowest.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (r_dirty[i]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = PORT_W'(i);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_store    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_start = 1'b1;
                    w_next  = SHIFT;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (w_done) begin
                    w_next = STORE;
                end
            end
            STORE: begin
                w_store = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Set is applied after clear, so a write landing on the load edge keeps
    // the port dirty and its newest value gets converted next.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_wr_hit) begin
            w_set[w_wr_idx] = 1'b1;
        end
        if (w_start) begin
            w_clr[w_pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_dirty <= '0;
            r_port  <= '0;
            r_bin   <= '0;
        end else begin
            r_state <= w_next;
            r_dirty <= (r_dirty & ~w_clr) | w_set;
            if (w_start) begin
                r_port <= w_pick_idx;
            end
            if (w_wr_hit) begin
                if (w_wr_idx == PORT_W'(PORT_YEAR)) begin
                    r_bin[w_wr_idx] <= out_data;
                end else begin
                    r_bin[w_wr_idx] <= {{(DATA_W-8){1'b0}}, out_data[7:0]};
                end
            end
        end
    end

    bin2bcd_serial #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rstn     (rstn),
        .start    (w_start),
        .value    (r_bin[w_pick_idx]),
        .shift_en (w_shift_en),
        .done     (w_done),
        .bcd      (w_conv_bcd)
    );

    // Keeping only the displayed digits gives the mod-100 / mod-10000 behaviour.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bcd2     <= '0;
            r_year_bcd <= '0;
        end else if (w_store) begin
            if (r_port == PORT_W'(PORT_YEAR)) begin
                r_year_bcd <= w_conv_bcd[15:0];
            end else begin
                r_bcd2[r_port] <= w_conv_bcd[7:0];
            end
        end
    end

    assign w_unused_bcd = ^w_conv_bcd[BCD_W-1:16];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode <= MODE_HHMMSS;
        end else if (select_hhmmss_button) begin
            r_mode <= MODE_HHMMSS;
        end else if (select_yymmdd_button) begin
            r_mode <= MODE_YYMMDD;
        end else if (select_yyyymm_button) begin
            r_mode <= MODE_YYYYMM;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {r_d5, r_d4, r_d3, r_d2, r_d1, r_d0} <= '0;
        end else begin
            case (r_mode)
                MODE_YYMMDD: {r_d5, r_d4, r_d3, r_d2, r_d1, r_d0} <=
                    {r_year_bcd[7:0], r_bcd2[PORT_MONTH], r_bcd2[PORT_DAY]};
                MODE_YYYYMM: {r_d5, r_d4, r_d3, r_d2, r_d1, r_d0} <=
                    {r_year_bcd, r_bcd2[PORT_MONTH]};
                default:     {r_d5, r_d4, r_d3, r_d2, r_d1, r_d0} <=
                    {r_bcd2[PORT_HOUR], r_bcd2[PORT_MIN], r_bcd2[PORT_SEC]};
            endcase
        end
    end

    assign digit5 = r_d5;
    assign digit4 = r_d4;
    assign digit3 = r_d3;
    assign digit2 = r_d2;
    assign digit1 = r_d1;
    assign digit0 = r_d0;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_clock_digit_unit.sv
// tb/tb_clock_digit_unit.sv - scoreboard testbench for clock_digit_unit
module tb_clock_digit_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        write_out = 1'b0;
    logic [3:0]  out_port = '0;
    logic [15:0] out_data = '0;
    logic        btn_hms = 1'b0;
    logic        btn_ymd = 1'b0;
    logic        btn_yym = 1'b0;
    logic [3:0]  digit5, digit4, digit3, digit2, digit1, digit0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    clock_digit_unit #(.DATA_W(16), .NUM_PORTS(6), .BCD_DIGITS(5)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .write_out            (write_out),
        .out_port             (out_port),
        .out_data             (out_data),
        .select_hhmmss_button (btn_hms),
        .select_yymmdd_button (btn_ymd),
        .select_yyyymm_button (btn_yym),
        .digit5               (digit5),
        .digit4               (digit4),
        .digit3               (digit3),
        .digit2               (digit2),
        .digit1               (digit1),
        .digit0               (digit0),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] digits();
        return {digit5, digit4, digit3, digit2, digit1, digit0};
    endfunction

    task automatic check24(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: a busy falling edge marks a completed store; digits follow one cycle later.
    initial begin
        logic prev_busy;
        logic [23:0] exp;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_conversion: got %h expected none", digits());
                    end else begin
                        exp = exp_q.pop_front();
                        check24("conversion_digits", digits(), exp);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic wr(input logic [3:0] port, input logic [15:0] data);
        write_out = 1'b1;
        out_port  = port;
        out_data  = data;
        @(posedge clk); #1;
        write_out = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // which: 0 = hhmmss, 1 = yymmdd, 2 = yyyymm
    task automatic press(input int which);
        btn_hms = (which == 0);
        btn_ymd = (which == 1);
        btn_yym = (which == 2);
        @(posedge clk); #1;
        btn_hms = 1'b0;
        btn_ymd = 1'b0;
        btn_yym = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check24("reset_digits", digits(), 24'h000000);
        check1("reset_busy", busy, 1'b0);

        // Hour first (only dirty port at the load edge), then sec, then min.
        exp_q.push_back(24'h230000);
        exp_q.push_back(24'h230007);
        exp_q.push_back(24'h235907);
        wr(4'd2, 16'd23);
        wr(4'd1, 16'd59);
        wr(4'd0, 16'd7);
        drain();
        check24("hhmmss_23_59_07", digits(), 24'h235907);

        exp_q.push_back(24'h235907);
        exp_q.push_back(24'h235907);
        wr(4'd5, 16'd2023);
        wr(4'd4, 16'd12);
        drain();
        press(2);
        check24("yyyymm_2023_12", digits(), 24'h202312);
        exp_q.push_back(24'h202312);
        wr(4'd3, 16'd31);
        drain();
        press(1);
        check24("yymmdd_23_12_31", digits(), 24'h231231);
        press(0);
        check24("back_to_hhmmss", digits(), 24'h235907);

        // Rewrite of the port under conversion must be reconverted.
        exp_q.push_back(24'h235905);
        exp_q.push_back(24'h235942);
        wr(4'd0, 16'd5);
        repeat (4) @(posedge clk);
        #1;
        check1("busy_during_shift", busy, 1'b1);
        wr(4'd0, 16'd42);
        drain();
        check24("sec_rewrite_42", digits(), 24'h235942);

        // Out-of-range values and an ignored port index.
        exp_q.push_back(24'h235942);
        exp_q.push_back(24'h235950);
        wr(4'd5, 16'd65535);
        wr(4'd0, 16'd150);
        wr(4'd9, 16'd7);
        drain();
        check24("sec_150_mod100", digits(), 24'h235950);
        press(2);
        check24("year_65535_mod10000", digits(), 24'h553512);
        check1("idle_after_ignored_port", busy, 1'b0);

        // Reset during the eighth shift cycle of a conversion.
        wr(4'd1, 16'd33);
        repeat (8) @(posedge clk);
        #1;
        check1("busy_before_reset", busy, 1'b1);
        rstn = 1'b0;
        #1;
        check24("digits_in_reset", digits(), 24'h000000);
        check1("busy_in_reset", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check24("no_store_after_reset", digits(), 24'h000000);
        check1("idle_after_reset", busy, 1'b0);

        // Mode must be back to HHMMSS after reset.
        exp_q.push_back(24'h120000);
        wr(4'd2, 16'd12);
        drain();
        check24("mode_reset_hhmmss", digits(), 24'h120000);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
